// File: rtl/sha256_padder_pkg.sv
// Shared types and helpers for the SHA-256 message padder.
// Holds the FSM state encoding, block geometry and byte-lane helpers.
package sha256_pkg;

  typedef enum logic [1:0] {FILL, PAD, EMIT, WAIT} state_t;

  localparam int          BLOCK_WORDS = 16;
  localparam logic [31:0] PAD_MARK    = 32'h0000_0080;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Keeps the low cnt bytes, places 0x80 right after them, zeroes the rest.
  function automatic logic [31:0] word_with_marker(input logic [31:0] data,
                                                   input logic [2:0]  cnt);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(cnt))
        w[i*8 +: 8] = data[i*8 +: 8];
      else if (i == int'(cnt))
        w[i*8 +: 8] = 8'h80;
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Stream bundle between the message source, the padder and the SHA-256 core input.
interface sha256_padder_if;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_data_i;
  logic [2:0]  s_cnt_i;
  logic        s_last_i;
  logic        m_valid_o;
  logic [31:0] m_data_o;

  modport slave (
    input  s_valid_i, s_data_i, s_cnt_i, s_last_i,
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, s_cnt_i, s_last_i,
    input  s_ready_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/sha256_pad_buf.sv
// 16x32 block buffer for the padder: one write port and one read port sharing an index.
module sha256_pad_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers a byte stream, appends marker/zeros/bit length, emits 512-bit blocks.
// Optional SHA256_PADDER_LEN_ERR_EN: saturating byte counter with sticky len_err_o.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  sha256_padder_if.slave bus,
  input  logic           core_busy_i,
  input  logic           core_done_i,
  output logic           msg_done_o,
  output logic           len_err_o
);

  state_t           state;
  logic [3:0]       widx;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_next;
  logic             last_seen;
  logic             mark_done;
  logic             len_here;
  logic [2:0]       n_bytes;
  logic [63:0]      bitlen;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;

  assign n_bytes = (bus.s_cnt_i > 3'd4) ? 3'd4 : bus.s_cnt_i;
  assign bitlen  = 64'(byte_cnt) << 3;

`ifdef SHA256_PADDER_LEN_ERR_EN
  logic             cnt_carry;
  logic [LEN_W-1:0] cnt_sum;
  logic             len_err_q;

  assign {cnt_carry, cnt_sum} = {1'b0, byte_cnt} + (LEN_W+1)'(n_bytes);
  assign cnt_next  = cnt_carry ? '1 : cnt_sum;
  assign len_err_o = len_err_q;
`else
  assign cnt_next  = byte_cnt + LEN_W'(n_bytes);
  assign len_err_o = 1'b0;
`endif

  // The length goes at word 14 only if the marker already sits in an earlier word.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    if (state == FILL && bus.s_valid_i) begin
      wr_en = 1'b1;
      if (bus.s_last_i && n_bytes != 3'd4)
        wr_data = word_with_marker(bus.s_data_i, n_bytes);
      else if (n_bytes != 3'd0)
        wr_data = bus.s_data_i;
    end else if (state == PAD) begin
      wr_en = 1'b1;
      if (!mark_done)
        wr_data = PAD_MARK;
      else if (widx == 4'd14)
        wr_data = bswap32(bitlen[63:32]);
      else if (widx == 4'd15 && len_here)
        wr_data = bswap32(bitlen[31:0]);
    end
  end

  sha256_pad_buf u_buf (
    .clk   (clk),
    .we    (wr_en),
    .idx   (widx),
    .wdata (wr_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      widx          <= '0;
      byte_cnt      <= '0;
      last_seen     <= 1'b0;
      mark_done     <= 1'b0;
      len_here      <= 1'b0;
      bus.s_ready_o <= 1'b1;
      bus.m_valid_o <= 1'b0;
      bus.m_data_o  <= '0;
      msg_done_o    <= 1'b0;
`ifdef SHA256_PADDER_LEN_ERR_EN
      len_err_q     <= 1'b0;
`endif
    end else begin
      msg_done_o <= 1'b0;
      case (state)
        FILL: begin
          if (bus.s_valid_i) begin
            byte_cnt <= cnt_next;
`ifdef SHA256_PADDER_LEN_ERR_EN
            if (cnt_carry)
              len_err_q <= 1'b1;
`endif
            widx <= widx + 4'd1;
            if (bus.s_last_i) begin
              last_seen <= 1'b1;
              if (n_bytes != 3'd4)
                mark_done <= 1'b1;
            end
            if (widx == 4'd15) begin
              state         <= EMIT;
              bus.s_ready_o <= 1'b0;
            end else if (bus.s_last_i) begin
              state         <= PAD;
              bus.s_ready_o <= 1'b0;
            end
          end
        end
        PAD: begin
          if (!mark_done)
            mark_done <= 1'b1;
          else if (widx == 4'd14)
            len_here <= 1'b1;
          widx <= widx + 4'd1;
          if (widx == 4'd15)
            state <= EMIT;
        end
        // widx doubles as the read pointer; its wrap back to 0 marks the 16th beat.
        EMIT: begin
          if (!bus.m_valid_o) begin
            if (!core_busy_i) begin
              bus.m_valid_o <= 1'b1;
              bus.m_data_o  <= rd_data;
              widx          <= widx + 4'd1;
            end
          end else if (widx == 4'd0) begin
            bus.m_valid_o <= 1'b0;
            bus.m_data_o  <= '0;
            state         <= WAIT;
          end else begin
            bus.m_data_o <= rd_data;
            widx         <= widx + 4'd1;
          end
        end
        WAIT: begin
          if (core_done_i) begin
            widx <= '0;
            if (len_here) begin
              msg_done_o    <= 1'b1;
              last_seen     <= 1'b0;
              mark_done     <= 1'b0;
              len_here      <= 1'b0;
              byte_cnt      <= '0;
              state         <= FILL;
              bus.s_ready_o <= 1'b1;
            end else if (last_seen) begin
              state <= PAD;
            end else begin
              state         <= FILL;
              bus.s_ready_o <= 1'b1;
            end
          end
        end
        default: begin
          state         <= FILL;
          bus.s_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
